// File: rtl/ring_phase_decoder.sv
// ring_phase_decoder: samples a rotating one-hot phase bus, decodes the set
// bit to a binary slot index, checks one-hot-ness and right-rotate order
// (MSB first, toward bit 0, wrap to MSB), and acquires/tracks lock.
// Optional build macro RING_PHASE_DEC_ERRCNT_EN adds a saturating 8-bit
// error counter; without it err_count is tied to zero.
module ring_phase_decoder #(
  parameter  int WIDTH    = 8,
  parameter  int LOCK_CNT = 4,
  localparam int IDXW     = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              phase_valid,
  input  logic [WIDTH-1:0]  phase_in,
  output logic [IDXW-1:0]   index,
  output logic              index_valid,
  output logic              locked,
  output logic              lap_tick,
  output logic              err_onehot,
  output logic              err_seq,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCK} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [4:0]       LOCK_TGT = 5'(LOCK_CNT);

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  // Binary position of the (single) set bit.
  function automatic logic [IDXW-1:0] encode(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) r = IDXW'(i);
    return r;
  endfunction

  state_t            state_p1, state_nx;
  logic [WIDTH-1:0]  ref_p1, ref_nx;
  logic [3:0]        good_p1, good_nx;
  logic [IDXW-1:0]   index_p1, index_nx;
  logic              iv_p1, iv_nx;
  logic              lap_p1, lap_nx;
  logic              eoh_p1, eoh_nx;
  logic              eseq_p1, eseq_nx;

  logic [WIDTH-1:0]  exp_p0;
  logic              onehot_p0, match_p0;
  logic [IDXW-1:0]   enc_p0;
  logic [4:0]        good_inc_p0;

  assign exp_p0      = {ref_p1[0], ref_p1[WIDTH-1:1]};
  assign onehot_p0   = is_onehot(phase_in);
  assign match_p0    = (phase_in == exp_p0);
  assign enc_p0      = encode(phase_in);
  assign good_inc_p0 = {1'b0, good_p1} + 5'd1;

  // Next-state and next-output decode; invalid cycles leave everything as is.
  always_comb begin
    state_nx = state_p1;
    ref_nx   = ref_p1;
    good_nx  = good_p1;
    index_nx = index_p1;
    iv_nx    = 1'b0;
    lap_nx   = 1'b0;
    eoh_nx   = 1'b0;
    eseq_nx  = 1'b0;
    if (phase_valid) begin
      case (state_p1)
        HUNT: begin
          if (onehot_p0) begin
            ref_nx   = phase_in;
            good_nx  = '0;
            index_nx = enc_p0;
            iv_nx    = 1'b1;
            state_nx = TRACK;
          end else begin
            eoh_nx = 1'b1;
          end
        end
        TRACK: begin
          if (!onehot_p0) begin
            eoh_nx   = 1'b1;
            state_nx = HUNT;
          end else if (match_p0) begin
            ref_nx   = phase_in;
            index_nx = enc_p0;
            iv_nx    = 1'b1;
            if (good_inc_p0 == LOCK_TGT) begin
              good_nx  = '0;
              state_nx = LOCK;
            end else begin
              good_nx = good_inc_p0[3:0];
            end
          end else begin
            // Wrong rotation (including a stalled repeat): resync on it.
            eseq_nx  = 1'b1;
            ref_nx   = phase_in;
            good_nx  = '0;
            index_nx = enc_p0;
            iv_nx    = 1'b1;
          end
        end
        LOCK: begin
          if (!onehot_p0) begin
            eoh_nx   = 1'b1;
            state_nx = HUNT;
          end else if (match_p0) begin
            ref_nx   = phase_in;
            index_nx = enc_p0;
            iv_nx    = 1'b1;
            lap_nx   = (phase_in == MSB) && (ref_p1 == ONE);
          end else begin
            eseq_nx  = 1'b1;
            ref_nx   = phase_in;
            good_nx  = '0;
            index_nx = enc_p0;
            iv_nx    = 1'b1;
            state_nx = TRACK;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  // ---- stage boundary: decoded sample -> registered state and outputs ----
  // State and output registers; reset wins over any sample in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= HUNT;
      ref_p1   <= '0;
      good_p1  <= '0;
      index_p1 <= '0;
      iv_p1    <= 1'b0;
      lap_p1   <= 1'b0;
      eoh_p1   <= 1'b0;
      eseq_p1  <= 1'b0;
    end else begin
      state_p1 <= state_nx;
      ref_p1   <= ref_nx;
      good_p1  <= good_nx;
      index_p1 <= index_nx;
      iv_p1    <= iv_nx;
      lap_p1   <= lap_nx;
      eoh_p1   <= eoh_nx;
      eseq_p1  <= eseq_nx;
    end
  end

  assign index       = index_p1;
  assign index_valid = iv_p1;
  assign locked      = (state_p1 == LOCK);
  assign lap_tick    = lap_p1;
  assign err_onehot  = eoh_p1;
  assign err_seq     = eseq_p1;

`ifdef RING_PHASE_DEC_ERRCNT_EN
  logic [7:0] err_cnt_p1;

  // Saturating error counter, stepping on the same edge as the error pulse.
  always_ff @(posedge clk) begin
    if (reset)
      err_cnt_p1 <= '0;
    else if ((eoh_nx || eseq_nx) && (err_cnt_p1 != 8'hFF))
      err_cnt_p1 <= err_cnt_p1 + 8'd1;
  end

  assign err_count = err_cnt_p1;
`else
  assign err_count = '0;
`endif

endmodule
